// File: rtl/fifo_pkg.sv
// Shared FIFO defaults and Gray-code helpers, used by both read- and write-side pointer blocks.
package fifo_pkg;

  localparam int unsigned DATASIZE_DEF = 8;
  localparam int unsigned ADDRSIZE_DEF = 4;

  // Output register occupancy: dout empty or holding an unconsumed word
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_e;

  // Helpers work on a zero-extended 32-bit word; callers narrow the result with a width cast
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_port_if.sv
// Read-port bundle: memory read path, pointer exchange and the consumer handshake.
interface fifo_rd_port_if
  import fifo_pkg::*;
#(
  parameter int unsigned DATASIZE = DATASIZE_DEF,
  parameter int unsigned ADDRSIZE = ADDRSIZE_DEF
) ();

  logic [ADDRSIZE:0]   rq2_wptr;
  logic [DATASIZE-1:0] rdata;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr;
  logic                rempty;
  logic [ADDRSIZE:0]   rlevel;
  logic [DATASIZE-1:0] dout;
  logic                dout_valid;
  logic                dout_ready;

  // Read-port block side
  modport master (
    input  rq2_wptr, rdata, dout_ready,
    output raddr, rptr, rempty, rlevel, dout, dout_valid
  );

  // Memory / write-side / consumer side
  modport slave (
    output rq2_wptr, rdata, dout_ready,
    input  raddr, rptr, rempty, rlevel, dout, dout_valid
  );

endinterface

// File: rtl/fifo_rd_outreg.sv
// Output register stage: decides when a memory word is popped and holds it until consumed.
module fifo_rd_outreg
  import fifo_pkg::*;
#(
  parameter int unsigned DATASIZE = DATASIZE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rempty,
  input  logic [DATASIZE-1:0] rdata,
  input  logic                dout_ready,
  output logic                pop_c,
  output logic [DATASIZE-1:0] dout,
  output logic                dout_valid
);

  out_state_e          state_q, state_d;
  logic [DATASIZE-1:0] dout_q, dout_d;

  // State and data register; reset discards any held word
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OUT_EMPTY;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
    end
  end

  // Pop whenever a word is available and the register is free or being drained
  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    pop_c   = 1'b0;
    case (state_q)
      OUT_EMPTY: begin
        if (!rempty) begin
          pop_c   = 1'b1;
          dout_d  = rdata;
          state_d = OUT_VALID;
        end
      end
      OUT_VALID: begin
        if (dout_ready) begin
          if (!rempty) begin
            pop_c  = 1'b1;
            dout_d = rdata;
          end else begin
            state_d = OUT_EMPTY;
          end
        end
      end
    endcase
  end

  assign dout       = dout_q;
  assign dout_valid = (state_q == OUT_VALID);

endmodule

// File: rtl/fifo_rd_port.sv
// Async-FIFO read port: Gray/binary read pointer, empty flag, fill level and output register.
module fifo_rd_port
  import fifo_pkg::*;
#(
  parameter int unsigned DATASIZE = DATASIZE_DEF,
  parameter int unsigned ADDRSIZE = ADDRSIZE_DEF
) (
  input  logic           rclk,
  input  logic           rrst,
  fifo_rd_port_if.master rif
);

  localparam int unsigned PTRW = ADDRSIZE + 1;

  logic [PTRW-1:0] rbin_q, rbin_d;
  logic [PTRW-1:0] rptr_q, rptr_d;
  logic [PTRW-1:0] rlevel_q, rlevel_d;
  logic [PTRW-1:0] wbin_c;
  logic            rempty_q, rempty_d;
  logic            pop_c;

  fifo_rd_outreg #(
    .DATASIZE (DATASIZE)
  ) u_outreg (
    .clk        (rclk),
    .rst        (rrst),
    .rempty     (rempty_q),
    .rdata      (rif.rdata),
    .dout_ready (rif.dout_ready),
    .pop_c      (pop_c),
    .dout       (rif.dout),
    .dout_valid (rif.dout_valid)
  );

  // Next pointer, empty flag and level all look ahead through this cycle's pop
  always_comb begin
    wbin_c   = PTRW'(gray2bin(32'(rif.rq2_wptr)));
    rbin_d   = rbin_q + PTRW'(pop_c);
    rptr_d   = PTRW'(bin2gray(32'(rbin_d)));
    rempty_d = (rptr_d == rif.rq2_wptr);
    rlevel_d = wbin_c - rbin_d;
  end

  // Pointer and flag registers
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
      rlevel_q <= '0;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rptr_d;
      rempty_q <= rempty_d;
      rlevel_q <= rlevel_d;
    end
  end

  assign rif.raddr  = rbin_q[ADDRSIZE-1:0];
  assign rif.rptr   = rptr_q;
  assign rif.rempty = rempty_q;
  assign rif.rlevel = rlevel_q;

endmodule

// File: tb/tb_fifo_rd_port.sv
// Bench for fifo_rd_port: queue-based reference model, per-cycle compare, directed and random traffic.
module tb_fifo_rd_port;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic rclk = 1'b0;
  logic rrst = 1'b1;
  always #5 rclk = ~rclk;

  fifo_rd_port_if #(.DATASIZE(DW), .ADDRSIZE(AW)) rif ();

  fifo_rd_port #(.DATASIZE(DW), .ADDRSIZE(AW)) dut (
    .rclk (rclk),
    .rrst (rrst),
    .rif  (rif)
  );

  // Memory emulation: combinational read
  logic [DW-1:0] mem [DEPTH];
  assign rif.rdata = mem[rif.raddr];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Write side: total words written and the words still to be delivered, in order
  int            wcnt = 0;
  logic [DW-1:0] wq[$];

  // Reference model: words consumed from memory and the output register contents
  int            m_rcnt  = 0;
  int            m_level = 0;
  bit            m_empty = 1'b1;
  bit            m_valid = 1'b0;
  logic [DW-1:0] m_dout  = '0;

  function automatic logic [AW:0] gray5(input int n);
    logic [AW:0] b;
    b = (AW+1)'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    mem[wcnt % DEPTH] = d;
    wq.push_back(d);
    wcnt++;
    rif.rq2_wptr = gray5(wcnt);
  endtask

  task automatic reset_write_side();
    wcnt = 0;
    wq.delete();
    rif.rq2_wptr = '0;
  endtask

  // Model: a word leaves memory when one is visible and the output slot is free or draining
  always @(posedge rclk) begin
    bit pop;
    if (rrst) begin
      m_rcnt  = 0;
      m_valid = 1'b0;
      m_dout  = '0;
      m_empty = 1'b1;
      m_level = 0;
    end else begin
      pop = !m_empty && (!m_valid || rif.dout_ready);
      if (pop) begin
        m_dout  = wq.pop_front();
        m_valid = 1'b1;
        m_rcnt++;
      end else if (rif.dout_ready) begin
        m_valid = 1'b0;
      end
      m_level = wcnt - m_rcnt;
      m_empty = (m_level == 0);
    end
  end

  // Every-cycle compare against the model
  always @(negedge rclk) begin
    if (chk_en) begin
      check("dout_valid", 32'(rif.dout_valid), 32'(m_valid));
      check("dout",       32'(rif.dout),       32'(m_dout));
      check("rempty",     32'(rif.rempty),     32'(m_empty));
      check("rlevel",     32'(rif.rlevel),     32'(m_level));
      check("rptr",       32'(rif.rptr),       32'(gray5(m_rcnt)));
      check("raddr",      32'(rif.raddr),      32'(m_rcnt % DEPTH));
    end
  end

  initial begin
    int            exp_addr [4];
    bit            rdy_pat  [5];
    logic [DW-1:0] dout_pat [5];
    bit            vld_pat  [5];

    for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
    rif.rq2_wptr   = '0;
    rif.dout_ready = 1'b0;

    // Reset values
    @(negedge rclk);
    chk_en = 1'b1;
    check("rst_rempty", 32'(rif.rempty), 32'd1);
    check("rst_valid",  32'(rif.dout_valid), 32'd0);
    check("rst_rptr",   32'(rif.rptr), 32'd0);
    check("rst_rlevel", 32'(rif.rlevel), 32'd0);
    check("rst_dout",   32'(rif.dout), 32'd0);
    rrst = 1'b0;

    // Single word, consumer stalled
    write_word(8'hA5);
    @(negedge rclk);
    check("one_rempty", 32'(rif.rempty), 32'd0);
    check("one_rlevel", 32'(rif.rlevel), 32'd1);
    check("one_valid0", 32'(rif.dout_valid), 32'd0);
    @(negedge rclk);
    check("one_valid", 32'(rif.dout_valid), 32'd1);
    check("one_dout",  32'(rif.dout), 32'hA5);
    check("one_rptr",  32'(rif.rptr), 32'd1);
    check("one_empty", 32'(rif.rempty), 32'd1);
    repeat (3) @(negedge rclk);
    check("one_hold_dout",  32'(rif.dout), 32'hA5);
    check("one_hold_valid", 32'(rif.dout_valid), 32'd1);

    // Full memory, drained back-to-back
    rrst = 1'b1;
    reset_write_side();
    @(negedge rclk);
    rrst = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) write_word(8'(i * 7 + 3));
    rif.dout_ready = 1'b1;
    @(negedge rclk);
    check("full_rlevel", 32'(rif.rlevel), 32'd16);
    check("full_model_level", 32'(m_level), 32'd16);
    check("full_rempty", 32'(rif.rempty), 32'd0);
    for (int k = 0; k < int'(DEPTH); k++) begin
      @(negedge rclk);
      check("b2b_valid",  32'(rif.dout_valid), 32'd1);
      check("b2b_dout",   32'(rif.dout), 32'(8'(k * 7 + 3)));
      check("b2b_rlevel", 32'(rif.rlevel), 32'(15 - k));
      check("b2b_raddr",  32'(rif.raddr), 32'((k + 1) % 16));
    end
    check("b2b_rempty", 32'(rif.rempty), 32'd1);
    @(negedge rclk);
    check("b2b_valid_end", 32'(rif.dout_valid), 32'd0);

    // Advance read pointer to 30, then read across the pointer wrap
    for (int i = 0; i < 14; i++) begin
      write_word(8'($urandom));
      @(negedge rclk);
    end
    repeat (4) @(negedge rclk);
    check("pre_wrap_rptr",  32'(rif.rptr), 32'd17);
    check("pre_wrap_raddr", 32'(rif.raddr), 32'd14);
    for (int i = 0; i < 4; i++) write_word(8'(8'hC0 + i));
    @(negedge rclk);
    check("wrap_raddr0", 32'(rif.raddr), 32'd14);
    check("wrap_rlevel", 32'(rif.rlevel), 32'd4);
    exp_addr = '{15, 0, 1, 2};
    for (int k = 0; k < 4; k++) begin
      @(negedge rclk);
      check("wrap_dout",  32'(rif.dout), 32'(8'(8'hC0 + k)));
      check("wrap_raddr", 32'(rif.raddr), 32'(exp_addr[k]));
    end
    check("wrap_rptr",   32'(rif.rptr), 32'd3);
    check("wrap_rempty", 32'(rif.rempty), 32'd1);

    // Backpressure with three queued words
    @(negedge rclk);
    rif.dout_ready = 1'b0;
    write_word(8'h11);
    write_word(8'h22);
    write_word(8'h33);
    repeat (2) @(negedge rclk);
    check("bp_dout0",   32'(rif.dout), 32'h11);
    check("bp_rlevel0", 32'(rif.rlevel), 32'd2);
    rdy_pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    dout_pat = '{8'h22, 8'h22, 8'h22, 8'h33, 8'h33};
    vld_pat  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 5; k++) begin
      rif.dout_ready = rdy_pat[k];
      @(negedge rclk);
      check("bp_dout",  32'(rif.dout), 32'(dout_pat[k]));
      check("bp_valid", 32'(rif.dout_valid), 32'(vld_pat[k]));
    end

    // Reset in the middle of a transfer
    rif.dout_ready = 1'b0;
    for (int i = 0; i < 6; i++) write_word(8'(8'h50 + i));
    repeat (2) @(negedge rclk);
    check("mid_valid",  32'(rif.dout_valid), 32'd1);
    check("mid_rlevel", 32'(rif.rlevel), 32'd5);
    check("mid_model_level", 32'(m_level), 32'd5);
    rrst = 1'b1;
    reset_write_side();
    rif.dout_ready = 1'b1;
    @(negedge rclk);
    check("mid_rst_valid",  32'(rif.dout_valid), 32'd0);
    check("mid_rst_rempty", 32'(rif.rempty), 32'd1);
    check("mid_rst_rptr",   32'(rif.rptr), 32'd0);
    check("mid_rst_rlevel", 32'(rif.rlevel), 32'd0);
    rrst = 1'b0;

    // Random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      rrst = 1'b0;
      rif.dout_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 499) == 0) begin
        rrst = 1'b1;
        reset_write_side();
      end else if ($urandom_range(0, 1) == 1 && (wcnt - m_rcnt) < int'(DEPTH)) begin
        write_word(8'($urandom));
      end
      @(negedge rclk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
